// File: rtl/vga_pkg.sv
// Shared types, colour constants and the bar colour lookup for the VGA pattern generator.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_CHECKER = 2'd0,
        MODE_VBARS   = 2'd1,
        MODE_HBARS   = 2'd2,
        MODE_IMAGE   = 2'd3
    } mode_t;

    // Colours packed as {r, g, b}, one bit per channel
    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] GREEN = 3'b010;
    localparam logic [2:0] BLUE  = 3'b001;
    localparam logic [2:0] BLACK = 3'b000;

    // Bar index k maps to R, G, B for k mod 3 = 0, 1, 2
    function automatic logic [2:0] color_of(input logic [3:0] k);
        case (k % 4'd3)
            4'd0:    color_of = RED;
            4'd1:    color_of = GREEN;
            default: color_of = BLUE;
        endcase
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster counters plus raw sync, active-region flags, pixel position and frame-boundary strobe.
module vga_timing #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 56,
    parameter int H_SYNC   = 120,
    parameter int H_BP     = 64,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 37,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 23,
    parameter int XW       = $clog2(H_SYNC + H_BP + H_ACTIVE + H_FP),
    parameter int YW       = $clog2(V_SYNC + V_BP + V_ACTIVE + V_FP)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          hs_on,
    output logic          vs_on,
    output logic          active,
    output logic          frame_bnd,
    output logic [XW-1:0] xpos,
    output logic [YW-1:0] ypos
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int H_START = H_SYNC + H_BP;
    localparam int V_START = V_SYNC + V_BP;

    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;
    logic          h_act;
    logic          v_act;

    // Pixel counter wraps every line; line counter steps and wraps only at end of line
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (x_cnt == XW'(H_TOTAL - 1)) begin
            x_cnt <= '0;
            y_cnt <= (y_cnt == YW'(V_TOTAL - 1)) ? '0 : y_cnt + YW'(1);
        end else begin
            x_cnt <= x_cnt + XW'(1);
        end
    end

    // Region decode from the counters
    always_comb begin
        hs_on     = (x_cnt < XW'(H_SYNC));
        vs_on     = (y_cnt < YW'(V_SYNC));
        h_act     = (x_cnt >= XW'(H_START)) && (x_cnt < XW'(H_START + H_ACTIVE));
        v_act     = (y_cnt >= YW'(V_START)) && (y_cnt < YW'(V_START + V_ACTIVE));
        active    = h_act && v_act;
        xpos      = x_cnt - XW'(H_START);
        ypos      = y_cnt - YW'(V_START);
        frame_bnd = (x_cnt == '0) && (y_cnt == '0);
    end

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: debounced mode button, frame-synchronous mode switch,
// bar/checker/ROM-image patterns and a two-stage output pipeline.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE     = 800,
    parameter int H_FP         = 56,
    parameter int H_SYNC       = 120,
    parameter int H_BP         = 64,
    parameter int V_ACTIVE     = 600,
    parameter int V_FP         = 37,
    parameter int V_SYNC       = 6,
    parameter int V_BP         = 23,
    parameter int SYNC_POL     = 0,
    parameter int COLOR_BITS   = 1,
    parameter int IMG_X        = 0,
    parameter int IMG_Y        = 0,
    parameter int IMG_W        = 180,
    parameter int IMG_H        = 150,
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               mode,
    output logic [$clog2(IMG_W*IMG_H)-1:0]     rom_addr,
    input  logic [2:0]                         rom_data,
    output logic                               hsync,
    output logic                               vsync,
    output logic                               de,
    output logic [COLOR_BITS-1:0]              r,
    output logic [COLOR_BITS-1:0]              g,
    output logic [COLOR_BITS-1:0]              b,
    output logic                               frame_start
);

    localparam int   XW    = $clog2(H_SYNC + H_BP + H_ACTIVE + H_FP);
    localparam int   YW    = $clog2(V_SYNC + V_BP + V_ACTIVE + V_FP);
    localparam int   AW    = $clog2(IMG_W * IMG_H);
    localparam int   DW    = $clog2(DEBOUNCE_CYC + 1);
    localparam int   BAR_W = H_ACTIVE / 8;
    localparam int   BAR_H = V_ACTIVE / 8;
    localparam logic SP    = (SYNC_POL != 0);

    logic          hs_on, vs_on, active, frame_bnd;
    logic [XW-1:0] xpos;
    logic [YW-1:0] ypos;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .XW       (XW),
        .YW       (YW)
    ) u_timing (
        .clk       (clk),
        .rst       (rst),
        .hs_on     (hs_on),
        .vs_on     (vs_on),
        .active    (active),
        .frame_bnd (frame_bnd),
        .xpos      (xpos),
        .ypos      (ypos)
    );

    logic          sync_0, sync_1, deb_level;
    logic [DW-1:0] deb_cnt;
    mode_t         pending_mode, active_mode;

    // Two-flop synchroniser for the asynchronous button
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_0 <= 1'b1;
            sync_1 <= 1'b1;
        end else begin
            sync_0 <= mode;
            sync_1 <= sync_0;
        end
    end

    // Debounce: accept a new level after DEBOUNCE_CYC consecutive differing samples; count presses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb_cnt      <= '0;
            deb_level    <= 1'b1;
            pending_mode <= MODE_CHECKER;
        end else if (sync_1 != deb_level) begin
            if (deb_cnt == DW'(DEBOUNCE_CYC - 1)) begin
                deb_cnt   <= '0;
                deb_level <= sync_1;
                if (!sync_1)
                    pending_mode <= mode_t'(pending_mode + 2'd1);
            end else begin
                deb_cnt <= deb_cnt + DW'(1);
            end
        end else begin
            deb_cnt <= '0;
        end
    end

    // Mode switches only at counter origin, so a frame never changes pattern part way
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            active_mode <= MODE_CHECKER;
        else if (frame_bnd)
            active_mode <= pending_mode;
    end

    logic signed [31:0] xi, yi;
    logic               in_win;
    logic [AW-1:0]      img_addr;

    // Image window test and linear ROM address
    always_comb begin
        xi       = $signed(32'(xpos));
        yi       = $signed(32'(ypos));
        in_win   = active && (xi >= IMG_X) && (xi < IMG_X + IMG_W)
                          && (yi >= IMG_Y) && (yi < IMG_Y + IMG_H);
        img_addr = AW'((yi - IMG_Y) * IMG_W + (xi - IMG_X));
    end

    logic       s1_hs, s1_vs, s1_act, s1_win, s1_first;
    logic [3:0] s1_cx, s1_ry;
    mode_t      s1_mode;

    // Stage 1: ROM address, region flags, bar indices; mode travels with the pixel
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_hs    <= 1'b0;
            s1_vs    <= 1'b0;
            s1_act   <= 1'b0;
            s1_win   <= 1'b0;
            s1_first <= 1'b0;
            s1_cx    <= '0;
            s1_ry    <= '0;
            s1_mode  <= MODE_CHECKER;
            rom_addr <= '0;
        end else begin
            s1_hs    <= hs_on;
            s1_vs    <= vs_on;
            s1_act   <= active;
            s1_win   <= in_win;
            s1_first <= active && (xpos == '0) && (ypos == '0);
            s1_cx    <= 4'(xpos / XW'(BAR_W));
            s1_ry    <= 4'(ypos / YW'(BAR_H));
            s1_mode  <= active_mode;
            rom_addr <= (in_win && (active_mode == MODE_IMAGE)) ? img_addr : '0;
        end
    end

    logic [2:0] pix;

    // Pattern select; parity of cx+ry is the XOR of their LSBs
    always_comb begin
        pix = BLACK;
        if (s1_act) begin
            case (s1_mode)
                MODE_CHECKER: pix = (s1_cx[0] ^ s1_ry[0]) ? color_of(s1_ry + 4'd1) : color_of(s1_cx);
                MODE_VBARS:   pix = color_of(s1_cx);
                MODE_HBARS:   pix = color_of(s1_ry);
                default:      pix = s1_win ? rom_data : BLACK;
            endcase
        end
    end

    // Stage 2: registered colour with sync/de delayed to match
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hsync       <= ~SP;
            vsync       <= ~SP;
            de          <= 1'b0;
            r           <= '0;
            g           <= '0;
            b           <= '0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= s1_hs ? SP : ~SP;
            vsync       <= s1_vs ? SP : ~SP;
            de          <= s1_act;
            r           <= {COLOR_BITS{pix[2]}};
            g           <= {COLOR_BITS{pix[1]}};
            b           <= {COLOR_BITS{pix[0]}};
            frame_start <= s1_first;
        end
    end

endmodule
